exec_mem_stage: RTL and testbench

//  Registered stage directly downstream of the 16-bit ALU. Consumes the ALU result, cbz flag and

---
 rtl/exec_mem_stage.sv | 197 +++++++++++++++++++
 tb/tb_exec_mem_stage.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_mem_stage.sv
// exec_mem_stage: registered stage behind the 16-bit ALU.
// Accepts one operation per cycle when idle. Single-cycle ops produce a writeback or a
// branch strobe on the next cycle. LD/ST drive a req/ack data-memory bus, with a timeout
// that aborts the access and raises a sticky error flag.
module exec_mem_stage #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 3,
    parameter int MEM_TMO    = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inValid,
    output logic                  inReady,
    input  logic [1:0]            selType,
    input  logic [1:0]            selOp,
    input  logic [DATA_W-1:0]     aluRes,
    input  logic                  cbz,
    input  logic [DATA_W-1:0]     stData,
    input  logic [REG_ADDR_W-1:0] rdIdx,
    output logic                  memReq,
    output logic                  memWe,
    output logic [DATA_W-1:0]     memAddr,
    output logic [DATA_W-1:0]     memWdata,
    input  logic                  memAck,
    input  logic [DATA_W-1:0]     memRdata,
    output logic                  wbValid,
    output logic [REG_ADDR_W-1:0] wbIdx,
    output logic [DATA_W-1:0]     wbData,
    output logic                  brTaken,
    output logic [DATA_W-1:0]     brTarget,
    output logic                  memErr,
    input  logic                  errClr
);

    localparam int CNT_W = $clog2(MEM_TMO + 1);
    // Counter value on the last permitted wait cycle; the next edge would make it MEM_TMO.
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(MEM_TMO - 1);

    typedef enum logic {
        IDLE,
        MEM_WAIT
    } state_t;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        cnt, cnt_nxt;
    logic [REG_ADDR_W-1:0]   ld_idx, ld_idx_nxt;

    logic                    mem_req_nxt;
    logic                    mem_we_nxt;
    logic [DATA_W-1:0]       mem_addr_nxt;
    logic [DATA_W-1:0]       mem_wdata_nxt;
    logic                    wb_valid_nxt;
    logic [REG_ADDR_W-1:0]   wb_idx_nxt;
    logic [DATA_W-1:0]       wb_data_nxt;
    logic                    br_taken_nxt;
    logic [DATA_W-1:0]       br_target_nxt;
    logic                    mem_err_nxt;

    logic accept;
    logic is_wb_op;
    logic is_mem_op;
    logic is_bz;
    logic is_jmp;
    logic timeout;

    assign inReady   = (state == IDLE);
    assign accept    = inValid && (state == IDLE);
    // Arith/logic always write back; SET is type 10 with op 1x, SLT is type 11 with op 0x.
    assign is_wb_op  = !selType[1]
                     || (selType == 2'b10 && selOp[1])
                     || (selType == 2'b11 && !selOp[1]);
    assign is_mem_op = (selType == 2'b10) && !selOp[1];
    assign is_bz     = (selType == 2'b11) && (selOp == 2'b10);
    assign is_jmp    = (selType == 2'b11) && (selOp == 2'b11);
    assign timeout   = (cnt == TMO_LAST);

    // State register: only LD/ST leave IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: enter MEM_WAIT on a memory op, leave on ack or timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept && is_mem_op) begin
                    state_nxt = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (memAck || timeout) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: next values for the registered outputs, counter and latched load index.
    always_comb begin
        mem_req_nxt   = memReq;
        mem_we_nxt    = memWe;
        mem_addr_nxt  = memAddr;
        mem_wdata_nxt = memWdata;
        wb_valid_nxt  = 1'b0;
        wb_idx_nxt    = wbIdx;
        wb_data_nxt   = wbData;
        br_taken_nxt  = 1'b0;
        br_target_nxt = brTarget;
        mem_err_nxt   = errClr ? 1'b0 : memErr;
        cnt_nxt       = cnt;
        ld_idx_nxt    = ld_idx;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (accept) begin
                    if (is_wb_op) begin
                        wb_valid_nxt = 1'b1;
                        wb_data_nxt  = aluRes;
                        wb_idx_nxt   = rdIdx;
                    end
                    if (is_jmp || (is_bz && cbz)) begin
                        br_taken_nxt  = 1'b1;
                        br_target_nxt = aluRes;
                    end
                    if (is_mem_op) begin
                        mem_req_nxt  = 1'b1;
                        mem_we_nxt   = selOp[0];
                        mem_addr_nxt = aluRes;
                        ld_idx_nxt   = rdIdx;
                        if (selOp[0]) begin
                            mem_wdata_nxt = stData;
                        end
                    end
                end
            end
            MEM_WAIT: begin
                if (memAck) begin
                    mem_req_nxt = 1'b0;
                    cnt_nxt     = '0;
                    if (!memWe) begin
                        wb_valid_nxt = 1'b1;
                        wb_data_nxt  = memRdata;
                        wb_idx_nxt   = ld_idx;
                    end
                end else if (timeout) begin
                    mem_req_nxt = 1'b0;
                    mem_err_nxt = 1'b1;
                    cnt_nxt     = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                mem_req_nxt = 1'b0;
                cnt_nxt     = '0;
            end
        endcase
    end

    // Output and datapath registers, all cleared by reset so an abort never writes back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            memReq   <= 1'b0;
            memWe    <= 1'b0;
            memAddr  <= '0;
            memWdata <= '0;
            wbValid  <= 1'b0;
            wbIdx    <= '0;
            wbData   <= '0;
            brTaken  <= 1'b0;
            brTarget <= '0;
            memErr   <= 1'b0;
            cnt      <= '0;
            ld_idx   <= '0;
        end else begin
            memReq   <= mem_req_nxt;
            memWe    <= mem_we_nxt;
            memAddr  <= mem_addr_nxt;
            memWdata <= mem_wdata_nxt;
            wbValid  <= wb_valid_nxt;
            wbIdx    <= wb_idx_nxt;
            wbData   <= wb_data_nxt;
            brTaken  <= br_taken_nxt;
            brTarget <= br_target_nxt;
            memErr   <= mem_err_nxt;
            cnt      <= cnt_nxt;
            ld_idx   <= ld_idx_nxt;
        end
    end

endmodule

// File: tb/tb_exec_mem_stage.sv
// tb_exec_mem_stage: table of single-cycle ops plus hand-written LD/ST, timeout and reset
// sequences. Writebacks and branch strobes are matched against a queue of expected events.
module tb_exec_mem_stage;

    logic        clk;
    logic        rst_n;
    logic        inValid;
    logic        inReady;
    logic [1:0]  selType;
    logic [1:0]  selOp;
    logic [15:0] aluRes;
    logic        cbz;
    logic [15:0] stData;
    logic [2:0]  rdIdx;
    logic        memReq;
    logic        memWe;
    logic [15:0] memAddr;
    logic [15:0] memWdata;
    logic        memAck;
    logic [15:0] memRdata;
    logic        wbValid;
    logic [2:0]  wbIdx;
    logic [15:0] wbData;
    logic        brTaken;
    logic [15:0] brTarget;
    logic        memErr;
    logic        errClr;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        valid;
        logic [1:0]  sel_type;
        logic [1:0]  sel_op;
        logic [15:0] alu_res;
        logic        cbz;
        logic [2:0]  rd_idx;
        logic        exp_wb;
        logic        exp_br;
        logic [15:0] exp_data;
    } vec_t;

    typedef struct {
        logic        is_br;
        logic [2:0]  idx;
        logic [15:0] data;
    } sb_t;

    sb_t  sb_q[$];
    sb_t  sb_e;
    vec_t vecs[11];
    vec_t v;

    exec_mem_stage #(.DATA_W(16), .REG_ADDR_W(3), .MEM_TMO(4)) dut (
        .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(inReady),
        .selType(selType), .selOp(selOp), .aluRes(aluRes), .cbz(cbz),
        .stData(stData), .rdIdx(rdIdx), .memReq(memReq), .memWe(memWe),
        .memAddr(memAddr), .memWdata(memWdata), .memAck(memAck),
        .memRdata(memRdata), .wbValid(wbValid), .wbIdx(wbIdx),
        .wbData(wbData), .brTaken(brTaken), .brTarget(brTarget),
        .memErr(memErr), .errClr(errClr)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one op for a single accept edge, queue its expected result, return at next negedge.
    task automatic applyStimulus(input vec_t s, input logic [15:0] st_data);
        inValid = s.valid;
        selType = s.sel_type;
        selOp   = s.sel_op;
        aluRes  = s.alu_res;
        cbz     = s.cbz;
        rdIdx   = s.rd_idx;
        stData  = st_data;
        if (s.exp_wb) sb_q.push_back('{1'b0, s.rd_idx, s.exp_data});
        if (s.exp_br) sb_q.push_back('{1'b1, 3'd0, s.exp_data});
        @(negedge clk);
        inValid = 1'b0;
    endtask

    // Scoreboard: every writeback/branch strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && (wbValid || brTaken)) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL sb_unexpected: got wb=%b br=%b expected none at %0t",
                         wbValid, brTaken, $time);
            end else begin
                sb_e = sb_q.pop_front();
                checkOutput("sb_kind", {14'd0, wbValid, brTaken}, {14'd0, !sb_e.is_br, sb_e.is_br});
                checkOutput("sb_data", wbValid ? wbData : brTarget, sb_e.data);
                if (!sb_e.is_br) checkOutput("sb_idx", {13'd0, wbIdx}, {13'd0, sb_e.idx});
            end
        end
    end

    initial begin
        // valid type op  aluRes  cbz rd  wb  br  data
        vecs[0]  = '{1'b1, 2'b00, 2'b00, 16'h1234, 1'b0, 3'd3, 1'b1, 1'b0, 16'h1234};
        vecs[1]  = '{1'b1, 2'b01, 2'b10, 16'h00FF, 1'b0, 3'd5, 1'b1, 1'b0, 16'h00FF};
        vecs[2]  = '{1'b1, 2'b10, 2'b10, 16'h7777, 1'b0, 3'd1, 1'b1, 1'b0, 16'h7777};
        vecs[3]  = '{1'b1, 2'b10, 2'b11, 16'h0001, 1'b0, 3'd7, 1'b1, 1'b0, 16'h0001};
        vecs[4]  = '{1'b1, 2'b11, 2'b00, 16'h0001, 1'b0, 3'd2, 1'b1, 1'b0, 16'h0001};
        vecs[5]  = '{1'b1, 2'b11, 2'b01, 16'h0000, 1'b0, 3'd0, 1'b1, 1'b0, 16'h0000};
        vecs[6]  = '{1'b1, 2'b11, 2'b10, 16'h0200, 1'b1, 3'd4, 1'b0, 1'b1, 16'h0200};
        vecs[7]  = '{1'b1, 2'b11, 2'b10, 16'h0300, 1'b0, 3'd4, 1'b0, 1'b0, 16'h0000};
        vecs[8]  = '{1'b1, 2'b11, 2'b11, 16'h0400, 1'b0, 3'd6, 1'b0, 1'b1, 16'h0400};
        vecs[9]  = '{1'b1, 2'b00, 2'b01, 16'hFFFF, 1'b1, 3'd6, 1'b1, 1'b0, 16'hFFFF};
        vecs[10] = '{1'b0, 2'b00, 2'b00, 16'h5555, 1'b0, 3'd2, 1'b0, 1'b0, 16'h0000};

        rst_n = 1'b0; inValid = 1'b0; selType = 2'b00; selOp = 2'b00; aluRes = 16'h0;
        cbz = 1'b0; stData = 16'h0; rdIdx = 3'd0; memAck = 1'b0; memRdata = 16'h0; errClr = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        checkOutput("rst_memReq",   {15'd0, memReq},  16'h0);
        checkOutput("rst_memWe",    {15'd0, memWe},   16'h0);
        checkOutput("rst_memAddr",  memAddr,          16'h0);
        checkOutput("rst_memWdata", memWdata,         16'h0);
        checkOutput("rst_wbValid",  {15'd0, wbValid}, 16'h0);
        checkOutput("rst_wbIdx",    {13'd0, wbIdx},   16'h0);
        checkOutput("rst_wbData",   wbData,           16'h0);
        checkOutput("rst_brTaken",  {15'd0, brTaken}, 16'h0);
        checkOutput("rst_brTarget", brTarget,         16'h0);
        checkOutput("rst_memErr",   {15'd0, memErr},  16'h0);
        checkOutput("rst_inReady",  {15'd0, inReady}, 16'h1);
        rst_n = 1'b1;
        @(negedge clk);

        // Single-cycle ops from the table, strobe presence checked one cycle after accept.
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i], 16'h0);
            checkOutput($sformatf("vec%0d_wbValid", i), {15'd0, wbValid}, {15'd0, vecs[i].exp_wb});
            checkOutput($sformatf("vec%0d_brTaken", i), {15'd0, brTaken}, {15'd0, vecs[i].exp_br});
        end

        // LD 0040, ack in the third request cycle with BEEF.
        v = '{1'b1, 2'b10, 2'b00, 16'h0040, 1'b0, 3'd4, 1'b0, 1'b0, 16'h0};
        sb_q.push_back('{1'b0, 3'd4, 16'hBEEF});
        applyStimulus(v, 16'h1111);
        for (int c = 0; c < 3; c++) begin
            checkOutput("ld_memReq",  {15'd0, memReq},  16'h1);
            checkOutput("ld_memWe",   {15'd0, memWe},   16'h0);
            checkOutput("ld_memAddr", memAddr,          16'h0040);
            checkOutput("ld_inReady", {15'd0, inReady}, 16'h0);
            if (c == 2) begin
                memAck = 1'b1;
                memRdata = 16'hBEEF;
            end
            @(negedge clk);
        end
        // Ack while idle must be ignored.
        memRdata = 16'hDEAD;
        checkOutput("ld_done_memReq",  {15'd0, memReq},  16'h0);
        checkOutput("ld_done_wbValid", {15'd0, wbValid}, 16'h1);
        checkOutput("ld_done_inReady", {15'd0, inReady}, 16'h1);
        @(negedge clk);
        memAck = 1'b0;
        checkOutput("stray_ack_wbValid", {15'd0, wbValid}, 16'h0);
        checkOutput("stray_ack_memReq",  {15'd0, memReq},  16'h0);

        // ST 0010 / A5A5, ack in the first request cycle: no writeback.
        v = '{1'b1, 2'b10, 2'b01, 16'h0010, 1'b0, 3'd2, 1'b0, 1'b0, 16'h0};
        applyStimulus(v, 16'hA5A5);
        checkOutput("st_memReq",   {15'd0, memReq}, 16'h1);
        checkOutput("st_memWe",    {15'd0, memWe},  16'h1);
        checkOutput("st_memAddr",  memAddr,         16'h0010);
        checkOutput("st_memWdata", memWdata,        16'hA5A5);
        memAck = 1'b1;
        @(negedge clk);
        memAck = 1'b0;
        checkOutput("st_done_memReq",  {15'd0, memReq},  16'h0);
        checkOutput("st_done_wbValid", {15'd0, wbValid}, 16'h0);
        @(negedge clk);

        // LD with no ack: four request cycles, then timeout sets the sticky error.
        v = '{1'b1, 2'b10, 2'b00, 16'h0050, 1'b0, 3'd5, 1'b0, 1'b0, 16'h0};
        applyStimulus(v, 16'h0);
        for (int c = 0; c < 4; c++) begin
            checkOutput("tmo_memReq", {15'd0, memReq}, 16'h1);
            @(negedge clk);
        end
        checkOutput("tmo_memReq_drop", {15'd0, memReq},  16'h0);
        checkOutput("tmo_memErr",      {15'd0, memErr},  16'h1);
        checkOutput("tmo_wbValid",     {15'd0, wbValid}, 16'h0);
        checkOutput("tmo_inReady",     {15'd0, inReady}, 16'h1);
        @(negedge clk);
        checkOutput("tmo_memErr_sticky", {15'd0, memErr}, 16'h1);
        errClr = 1'b1;
        @(negedge clk);
        errClr = 1'b0;
        checkOutput("errclr_memErr", {15'd0, memErr}, 16'h0);

        // Timeout and errClr on the same edge: the timeout wins.
        applyStimulus(v, 16'h0);
        for (int c = 0; c < 4; c++) begin
            if (c == 3) errClr = 1'b1;
            @(negedge clk);
        end
        errClr = 1'b0;
        checkOutput("tmo_vs_clr_memErr", {15'd0, memErr}, 16'h1);
        errClr = 1'b1;
        @(negedge clk);
        errClr = 1'b0;
        checkOutput("errclr2_memErr", {15'd0, memErr}, 16'h0);

        // Ack on the timeout edge: ack wins, writeback happens, no error.
        v = '{1'b1, 2'b10, 2'b00, 16'h0060, 1'b0, 3'd6, 1'b0, 1'b0, 16'h0};
        sb_q.push_back('{1'b0, 3'd6, 16'hCAFE});
        applyStimulus(v, 16'h0);
        for (int c = 0; c < 4; c++) begin
            checkOutput("tie_memReq", {15'd0, memReq}, 16'h1);
            if (c == 3) begin
                memAck = 1'b1;
                memRdata = 16'hCAFE;
            end
            @(negedge clk);
        end
        memAck = 1'b0;
        checkOutput("tie_memReq_drop", {15'd0, memReq},  16'h0);
        checkOutput("tie_memErr",      {15'd0, memErr},  16'h0);
        checkOutput("tie_wbValid",     {15'd0, wbValid}, 16'h1);
        @(negedge clk);

        // Reset in the middle of MEM_WAIT: request drops at once, nothing written back.
        v = '{1'b1, 2'b10, 2'b00, 16'h0070, 1'b0, 3'd1, 1'b0, 1'b0, 16'h0};
        applyStimulus(v, 16'h0);
        checkOutput("rstmid_memReq_pre", {15'd0, memReq}, 16'h1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rstmid_memReq",  {15'd0, memReq},  16'h0);
        checkOutput("rstmid_inReady", {15'd0, inReady}, 16'h1);
        @(negedge clk);
        memAck = 1'b1;
        memRdata = 16'h0BAD;
        rst_n = 1'b1;
        @(negedge clk);
        memAck = 1'b0;
        checkOutput("rstmid_after_wbValid", {15'd0, wbValid}, 16'h0);
        checkOutput("rstmid_after_inReady", {15'd0, inReady}, 16'h1);
        checkOutput("rstmid_after_memReq",  {15'd0, memReq},  16'h0);
        repeat (2) @(negedge clk);

        checkOutput("sb_empty", 16'(sb_q.size()), 16'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
